// File: rtl/sealing_ctrl_pkg.sv
// Shared constants for the bottle-line sealing station: state encodings and
// default timing/magazine parameters used by the RTL and the bench.
package sealing_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FEED  = 3'd1;
    localparam logic [2:0] ST_PRESS = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam int FEED_TO_DEF   = 8;
    localparam int PRESS_CYC_DEF = 4;
    localparam int CAP_MAX_DEF   = 15;
    localparam int LOW_TH_DEF    = 3;
    localparam int CW_DEF        = 4;

    // Width needed to count 0..max_val inclusive.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sealing_ctrl_cycle_timer.sv
// Shared phase timer: counts cycles spent in the current state and flags
// when the count reaches the terminal value selected by the caller.
module sealing_ctrl_cycle_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [TW-1:0] term_i,
    output logic          term_o
);

    logic [TW-1:0] cnt_q;

    // Up-counter; clear wins over count so every state change restarts at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign term_o = (cnt_q == term_i);

endmodule

// File: rtl/sealing_ctrl.sv
// Sealing station sequencer: feeds a cap, holds the press for a fixed time,
// reports completion to the line FSM, and tracks the cap magazine.
module sealing_ctrl
    import sealing_ctrl_pkg::*;
#(
    parameter int FEED_TO   = FEED_TO_DEF,
    parameter int PRESS_CYC = PRESS_CYC_DEF,
    parameter int CAP_MAX   = CAP_MAX_DEF,
    parameter int LOW_TH    = LOW_TH_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          pos_ve,
    input  logic          cap_ok,
    input  logic          refill,
    output logic          feeder,
    output logic          press,
    output logic          ve_done,
    output logic          fault,
    output logic          low_caps,
    output logic [CW-1:0] cap_count
);

    localparam int TW = timer_width(FEED_TO, PRESS_CYC);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cap_q, cap_d;
    logic          dec_s;
    logic          tmr_term_s;
    logic          tmr_en_s;
    logic          tmr_clr_s;
    logic [TW-1:0] tmr_term_val_s;

    // Next-state logic; the decrement is tied to the PRESS->DONE edge only.
    always_comb begin
        state_d = state_q;
        dec_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && pos_ve) begin
                    state_d = (cap_q != {CW{1'b0}}) ? ST_FEED : ST_FAULT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (cap_ok) begin
                    state_d = ST_PRESS;
                end else if (tmr_term_s) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_FEED;
                end
            end
            ST_PRESS: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (tmr_term_s) begin
                    state_d = ST_DONE;
                    dec_s   = 1'b1;
                end else begin
                    state_d = ST_PRESS;
                end
            end
            ST_DONE: begin
                if (!start || !pos_ve) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_FAULT: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Magazine: a refill overrides a coincident decrement.
    always_comb begin
        cap_d = cap_q;
        if (refill) begin
            cap_d = CW'(CAP_MAX);
        end else if (dec_s) begin
            cap_d = cap_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cap_d = cap_q;
        end
    end

    // Timer control: restart on any state change, run only in timed states.
    always_comb begin
        tmr_clr_s      = (state_d != state_q);
        tmr_en_s       = (state_q == ST_FEED) || (state_q == ST_PRESS);
        tmr_term_val_s = TW'(PRESS_CYC - 1);
        if (state_q == ST_FEED) begin
            tmr_term_val_s = TW'(FEED_TO - 1);
        end else begin
            tmr_term_val_s = TW'(PRESS_CYC - 1);
        end
    end

    sealing_ctrl_cycle_timer #(.TW(TW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (tmr_clr_s),
        .en_i   (tmr_en_s),
        .term_i (tmr_term_val_s),
        .term_o (tmr_term_s)
    );

    // State and magazine registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cap_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
        end
    end

    assign feeder    = (state_q == ST_FEED);
    assign press     = (state_q == ST_PRESS);
    assign ve_done   = (state_q == ST_DONE);
    assign fault     = (state_q == ST_FAULT);
    assign low_caps  = (cap_q <= CW'(LOW_TH));
    assign cap_count = cap_q;

endmodule

// File: tb/tb_sealing_ctrl.sv
// Directed bench for sealing_ctrl: a phase/age model checked every negedge
// plus literal expectations for the scenarios of interest.
module tb_sealing_ctrl;
    import sealing_ctrl_pkg::*;

    localparam int FEED_TO   = FEED_TO_DEF;
    localparam int PRESS_CYC = PRESS_CYC_DEF;
    localparam int CAP_MAX   = CAP_MAX_DEF;
    localparam int LOW_TH    = LOW_TH_DEF;
    localparam int CW        = CW_DEF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, pos_ve = 1'b0, cap_ok = 1'b0, refill = 1'b0;
    logic feeder, press, ve_done, fault, low_caps;
    logic [CW-1:0] cap_count;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    // Model: phase 0 idle, 1 feeding, 2 pressing, 3 done, 4 fault.
    int m_phase = 0;
    int m_age   = 0;
    int m_caps  = 0;

    sealing_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .pos_ve(pos_ve),
        .cap_ok(cap_ok), .refill(refill), .feeder(feeder), .press(press),
        .ve_done(ve_done), .fault(fault), .low_caps(low_caps), .cap_count(cap_count)
    );

    always #5 clk = ~clk;

    function automatic int next_phase(int ph, int age, int caps, logic st, logic pv, logic ok);
        if (ph == 0) return (st && pv) ? ((caps > 0) ? 1 : 4) : 0;
        if (ph == 1) return !st ? 0 : ok ? 2 : (age + 1 >= FEED_TO) ? 4 : 1;
        if (ph == 2) return !st ? 0 : (age + 1 >= PRESS_CYC) ? 3 : 2;
        if (ph == 3) return (!st || !pv) ? 0 : 3;
        if (ph == 4) return !st ? 0 : 4;
        return 0;
    endfunction

    function automatic int next_caps(int ph, int nph, int caps, logic rf);
        if (rf) return CAP_MAX;
        if (ph == 2 && nph == 3) return caps - 1;
        return caps;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
            m_age   <= 0;
            m_caps  <= 0;
        end else begin
            m_phase <= next_phase(m_phase, m_age, m_caps, start, pos_ve, cap_ok);
            m_age   <= (next_phase(m_phase, m_age, m_caps, start, pos_ve, cap_ok) == m_phase) ? m_age + 1 : 0;
            m_caps  <= next_caps(m_phase, next_phase(m_phase, m_age, m_caps, start, pos_ve, cap_ok), m_caps, refill);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && reset) begin
            check("m_feeder", int'(feeder), int'(m_phase == 1));
            check("m_press", int'(press), int'(m_phase == 2));
            check("m_ve_done", int'(ve_done), int'(m_phase == 3));
            check("m_fault", int'(fault), int'(m_phase == 4));
            check("m_cap_count", int'(cap_count), m_caps);
            check("m_low_caps", int'(low_caps), int'(m_caps <= LOW_TH));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_feeder", int'(feeder), 0);
        check("rst_press", int'(press), 0);
        check("rst_ve_done", int'(ve_done), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_cap_count", int'(cap_count), 0);
        check("rst_low_caps", int'(low_caps), 1);
        tick();
        reset = 1'b1;
        tick();
    endtask

    // One full seal with cap_ok held high; optional refill on the decrement edge.
    task automatic seal(input bit refill_late);
        int p;
        p = 0;
        pos_ve = 1'b1;
        cap_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (press) p++;
            if (ve_done) break;
            refill = (refill_late && p == PRESS_CYC) ? 1'b1 : 1'b0;
        end
        refill = 1'b0;
        check("seal_ve_done", int'(ve_done), 1);
        check("seal_press_len", p, PRESS_CYC);
        cap_ok = 1'b0;
        pos_ve = 1'b0;
        tick();
    endtask

    initial begin
        int f;
        int p;
        // Test 1: normal seal with cap_ok after the feeder has run 3 cycles.
        do_reset();
        cmp_en = 1'b1;
        refill = 1'b1;
        tick();
        refill = 1'b0;
        check("t1_refill", int'(cap_count), 15);
        start = 1'b1;
        pos_ve = 1'b1;
        f = 0;
        p = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (feeder) f++;
            if (press) p++;
            cap_ok = (feeder && f == 3) ? 1'b1 : 1'b0;
            if (ve_done) break;
        end
        cap_ok = 1'b0;
        check("t1_feeder_len", f, 3);
        check("t1_press_len", p, 4);
        check("t1_ve_done", int'(ve_done), 1);
        check("t1_cap_count", int'(cap_count), 14);
        tick();
        check("t1_done_held", int'(ve_done), 1);
        pos_ve = 1'b0;
        tick();
        check("t1_done_drop", int'(ve_done), 0);

        // Test 2: empty magazine faults immediately.
        start = 1'b0;
        cmp_en = 1'b0;
        do_reset();
        cmp_en = 1'b1;
        start = 1'b1;
        pos_ve = 1'b1;
        tick();
        check("t2_fault", int'(fault), 1);
        check("t2_feeder", int'(feeder), 0);
        cap_ok = 1'b1;
        tick();
        check("t2_fault_hold", int'(fault), 1);
        cap_ok = 1'b0;
        start = 1'b0;
        tick();
        check("t2_fault_clr", int'(fault), 0);
        refill = 1'b1;
        tick();
        refill = 1'b0;
        check("t2_refill", int'(cap_count), 15);
        pos_ve = 1'b0;
        tick();

        // Test 3: feed timeout.
        start = 1'b1;
        pos_ve = 1'b1;
        f = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (feeder) f++;
            if (fault) break;
        end
        check("t3_feeder_len", f, FEED_TO);
        check("t3_fault", int'(fault), 1);
        check("t3_cap_count", int'(cap_count), 15);
        pos_ve = 1'b0;
        tick();
        check("t3_fault_hold", int'(fault), 1);
        start = 1'b0;
        tick();
        check("t3_fault_clr", int'(fault), 0);

        // Test 4: abort during the second press cycle.
        start = 1'b1;
        pos_ve = 1'b1;
        tick();
        check("t4_feeder", int'(feeder), 1);
        cap_ok = 1'b1;
        tick();
        cap_ok = 1'b0;
        check("t4_press1", int'(press), 1);
        tick();
        check("t4_press2", int'(press), 1);
        start = 1'b0;
        tick();
        check("t4_press_drop", int'(press), 0);
        check("t4_no_done", int'(ve_done), 0);
        check("t4_cap_count", int'(cap_count), 15);
        pos_ve = 1'b0;
        tick();

        // Test 5: drain to the low threshold, then refill on the decrement edge.
        start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            seal(1'b0);
            if (k == 10) begin
                check("t5_cap4", int'(cap_count), 4);
                check("t5_low_at4", int'(low_caps), 0);
            end
        end
        check("t5_cap3", int'(cap_count), 3);
        check("t5_low_at3", int'(low_caps), 1);
        seal(1'b1);
        check("t5_refill_cap", int'(cap_count), 15);
        check("t5_refill_low", int'(low_caps), 0);

        // Test 6: asynchronous reset in the middle of feeding.
        pos_ve = 1'b1;
        tick();
        check("t6_feeder", int'(feeder), 1);
        #3 reset = 1'b0;
        #1;
        check("t6_feeder_async", int'(feeder), 0);
        check("t6_press_async", int'(press), 0);
        check("t6_fault_async", int'(fault), 0);
        check("t6_cap_async", int'(cap_count), 0);
        check("t6_low_async", int'(low_caps), 1);
        start = 1'b0;
        pos_ve = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("t6_idle", int'(feeder), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
